// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Shares one registered DW-bit data/valid bus between NREQ producers.
//   A round-robin pointer chooses the next owner. The owner may stream
//   up to MAX_BURST consecutive beats while other requesters wait.
//   Arbitration takes one idle cycle. Beats already held in the output
//   register still drain to the sink after the grant is released.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low (0 = reset)
//   req_valid  per-requester beat available
//   req_data   per-requester beat, requester i at [i*DW +: DW]
//   req_ready  per-requester accept strobe (combinational, owner only)
//   bus_data   registered shared-bus data
//   bus_valid  registered shared-bus valid
//   bus_ready  sink accepts bus_data this cycle
//   grant_id   current owner (meaningful while busy=1)
//   busy       arbiter is in the GRANT state
module bus_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           bus_data,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0]    ST_IDLE    = 1'b0;
  localparam logic [0:0]    ST_GRANT   = 1'b1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_ID    = IW'(NREQ - 1);

  logic [0:0]    state_r, state_n;
  logic [IW-1:0] ptr_r, ptr_n;
  logic [IW-1:0] grant_r, grant_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [CW-1:0] cnt_inc_s;
  logic [DW-1:0] bus_data_r, bus_data_n;
  logic          bus_valid_r, bus_valid_n;

  logic [NREQ-1:0] owner_oh_s;
  logic            busy_s;
  logic            can_load_s;
  logic            owner_valid_s;
  logic            accept_s;
  logic            others_s;
  logic [DW-1:0]   owner_data_s;
  logic            found_s;
  logic [IW-1:0]   winner_s;

  assign busy_s        = (state_r == ST_GRANT);
  assign can_load_s    = !bus_valid_r || bus_ready;
  assign owner_valid_s = req_valid[grant_r];
  assign accept_s      = busy_s && can_load_s && owner_valid_s;
  assign others_s      = |(req_valid & ~owner_oh_s);
  assign owner_data_s  = req_data[int'(grant_r)*DW +: DW];
  assign cnt_inc_s     = cnt_r + CW'(1);

  assign busy      = busy_s;
  assign grant_id  = grant_r;
  assign bus_data  = bus_data_r;
  assign bus_valid = bus_valid_r;

  // One-hot decode of the current owner
  always_comb begin
    owner_oh_s          = '0;
    owner_oh_s[grant_r] = 1'b1;
  end

  // Ready goes only to the owner, and only when the output register can take a beat
  always_comb begin
    if (busy_s && can_load_s) begin
      req_ready = owner_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  // Round-robin search ptr+1, ptr+2, ... (mod NREQ); first valid requester wins
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx      = (int'(ptr_r) + k >= NREQ) ? int'(ptr_r) + k - NREQ : int'(ptr_r) + k;
      winner_s = (!found_s && req_valid[idx]) ? IW'(idx) : winner_s;
      found_s  = found_s || req_valid[idx];
    end
  end

  // Arbitration FSM next-state: grant, burst counting and release
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    grant_n = grant_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_n = ST_GRANT;
          grant_n = winner_s;
          cnt_n   = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_valid_s) begin
          state_n = ST_IDLE;
          ptr_n   = grant_r;
          cnt_n   = '0;
        end else if (accept_s) begin
          if (cnt_inc_s == BURST_LAST) begin
            // Burst limit: hand over only if somebody else is waiting
            cnt_n = '0;
            if (others_s) begin
              state_n = ST_IDLE;
              ptr_n   = grant_r;
            end else begin
              state_n = ST_GRANT;
            end
          end else begin
            cnt_n = cnt_inc_s;
          end
        end else begin
          // Bus stalled: grant and count frozen
          cnt_n = cnt_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ptr_n   = LAST_ID;
        grant_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Output register next-state: load on accept, empty when the sink drains it
  always_comb begin
    bus_data_n  = bus_data_r;
    bus_valid_n = bus_valid_r;
    if (accept_s) begin
      bus_data_n  = owner_data_s;
      bus_valid_n = 1'b1;
    end else if (bus_ready) begin
      bus_valid_n = 1'b0;
    end else begin
      bus_valid_n = bus_valid_r;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= LAST_ID;
      grant_r     <= '0;
      cnt_r       <= '0;
      bus_data_r  <= '0;
      bus_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      grant_r     <= grant_n;
      cnt_r       <= cnt_n;
      bus_data_r  <= bus_data_n;
      bus_valid_r <= bus_valid_n;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter
//   Directed bench for bus_rr_arbiter (NREQ=4, DW=8, MAX_BURST=4).
//   Per-requester source queues feed the DUT. Every clock step records
//   which requester was accepted and what the bus delivered. A scoreboard
//   checks that each accepted beat appears on the bus exactly once and in
//   order. The per-step histories are compared with hand-derived sequences.
module tb_bus_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     bus_data;
  logic              bus_valid;
  logic              bus_ready;
  logic [1:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] src_q [NREQ][$];
  int exp_q[$];
  int hist_acc[$];
  int hist_bus[$];
  int hist_gid[$];
  int hist_busy[$];
  int hist_rdy[$];
  int hist_bv[$];
  int hist_bd[$];
  int e[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    check($sformatf("%s_len", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = src_q[i][0];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
      end
    end
  endtask

  task automatic clear_hist();
    hist_acc.delete();
    hist_bus.delete();
    hist_gid.delete();
    hist_busy.delete();
    hist_rdy.delete();
    hist_bv.delete();
    hist_bd.delete();
  endtask

  // One clock: sample at negedge, let the edge happen, then advance sources
  task automatic step();
    logic [NREQ-1:0] acc;
    int id;
    int x;
    @(negedge clk);
    acc = req_valid & req_ready;
    id  = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) id = i;
    end
    check("ready_onehot", int'($countones(req_ready) <= 1), 1);
    hist_acc.push_back(id);
    hist_gid.push_back(int'(grant_id));
    hist_busy.push_back(int'(busy));
    hist_rdy.push_back(int'(req_ready));
    hist_bv.push_back(int'(bus_valid));
    hist_bd.push_back(int'(bus_data));
    // Completing bus beat is older than any beat accepted at this edge
    if (bus_valid && bus_ready) begin
      hist_bus.push_back(int'(bus_data));
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("sb_data", int'(bus_data), x & 255);
      end else begin
        check("sb_extra", int'(bus_data), -1);
      end
    end else begin
      hist_bus.push_back(-1);
    end
    if (id >= 0) exp_q.push_back(id * 256 + int'(req_data[id*DW +: DW]));
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    drive_srcs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    drive_srcs();
    bus_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_valid", int'(bus_valid), 0);
    check("rst_bus_data", int'(bus_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_req_ready", int'(req_ready), 0);
    rst = 1'b1;
  endtask

  initial begin
    int ow[5];
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    bus_ready = 1'b1;

    // Test 1: req0 streams 0x11,0x22,0x33 straight after reset
    do_reset();
    clear_hist();
    src_q[0] = '{8'h11, 8'h22, 8'h33};
    drive_srcs();
    repeat (5) step();
    e = '{-1, 0, 0, 0, -1};
    check_seq("t1_acc", hist_acc, e);
    e = '{-1, -1, 8'h11, 8'h22, 8'h33};
    check_seq("t1_bus", hist_bus, e);
    check("t1_busy_arb", hist_busy[0], 0);
    check("t1_busy_grant", hist_busy[1], 1);
    check("t1_gid", hist_gid[1], 0);
    check("t1_busy_end", int'(busy), 0);
    check("t1_drain", exp_q.size(), 0);

    // Test 2: all four requesters valid, bursts of 4 with 1 idle cycle
    do_reset();
    clear_hist();
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'(8'h40 + k));
    for (int i = 1; i < NREQ; i++) begin
      for (int k = 0; k < 4; k++) src_q[i].push_back(8'(8'h40 + 16*i + k));
    end
    drive_srcs();
    repeat (26) step();
    ow = '{0, 1, 2, 3, 0};
    e.delete();
    e.push_back(-1);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < MAXB; k++) e.push_back(ow[b]);
      e.push_back(-1);
    end
    check_seq("t2_acc", hist_acc, e);
    check("t2_drain", exp_q.size(), 0);

    // Test 3: lone req2, 10 beats, grant kept across the burst limit
    clear_hist();
    for (int k = 0; k < 10; k++) src_q[2].push_back(8'(8'h20 + k));
    drive_srcs();
    repeat (12) step();
    e.delete();
    e.push_back(-1);
    for (int k = 0; k < 10; k++) e.push_back(2);
    e.push_back(-1);
    check_seq("t3_acc", hist_acc, e);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t3_bus[%0d]", k), hist_bus[k+2], 8'h20 + k);
    end
    check("t3_drain", exp_q.size(), 0);

    // Test 4: 5-cycle sink stall mid-burst; req1 waiting exposes the frozen count
    clear_hist();
    for (int k = 0; k < 6; k++) src_q[0].push_back(8'(8'hA0 + k));
    src_q[1] = '{8'hB0, 8'hB1};
    drive_srcs();
    repeat (3) step();
    bus_ready = 1'b0;
    repeat (5) step();
    bus_ready = 1'b1;
    repeat (10) step();
    e = '{-1, 0, 0, -1, -1, -1, -1, -1, 0, 0, -1, 1, 1, -1, -1, 0, 0, -1};
    check_seq("t4_acc", hist_acc, e);
    for (int s = 3; s < 8; s++) begin
      check($sformatf("t4_hold_valid[%0d]", s), hist_bv[s], 1);
      check($sformatf("t4_hold_data[%0d]", s), hist_bd[s], 8'hA1);
      check($sformatf("t4_hold_ready[%0d]", s), hist_rdy[s], 0);
    end
    check("t4_drain", exp_q.size(), 0);

    // Test 5: async reset mid-burst of req3, then req0 wins first
    clear_hist();
    for (int k = 0; k < 6; k++) src_q[3].push_back(8'(8'hD0 + k));
    drive_srcs();
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_valid", int'(bus_valid), 0);
    check("t5_async_data", int'(bus_data), 0);
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_gid", int'(grant_id), 0);
    check("t5_async_ready", int'(req_ready), 0);
    exp_q.delete();
    step();
    rst = 1'b1;
    clear_hist();
    src_q[0] = '{8'hC0, 8'hC1};
    drive_srcs();
    repeat (10) step();
    e = '{-1, 0, 0, -1, -1, 3, 3, 3, 3, -1};
    check_seq("t5_acc", hist_acc, e);
    check("t5_gid", hist_gid[1], 0);
    check("t5_drain", exp_q.size(), 0);

    // Test 6: ptr=3, req1 and req3 valid -> wrap search gives req1 then req3
    clear_hist();
    src_q[1] = '{8'h61, 8'h62};
    src_q[3] = '{8'h63, 8'h64};
    drive_srcs();
    repeat (8) step();
    e = '{-1, 1, 1, -1, -1, 3, 3, -1};
    check_seq("t6_acc", hist_acc, e);
    check("t6_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
